pixel_compositor: RTL and testbench

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/pixel_compositor_pix_out_reg.sv | 47 ++++
 rtl/pixel_compositor.sv | 137 +++++++++++++
 tb/tb_pixel_compositor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the pixel compositor: widths, colour-key
// defaults, frame geometry and the compositor FSM state encoding.
package gpu_pkg;

    localparam int unsigned LAYER_W = 5;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned PIX_W   = 16;
    localparam int unsigned ADDR_W  = LAYER_W + 2 * COORD_W;

    localparam logic [PIX_W-1:0]   DEF_KEY_COLOR = 16'hF81F;
    localparam logic [PIX_W-1:0]   DEF_BG_COLOR  = 16'h0000;
    localparam logic [COORD_W-1:0] DEF_X_LAST    = 11'd1919;
    localparam logic [COORD_W-1:0] DEF_Y_LAST    = 11'd1079;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        WAIT,
        EMIT
    } comp_state_t;

endpackage

// File: rtl/pixel_compositor_pix_out_reg.sv
// Valid/ready output register for the composited pixel stream: loads a pixel
// with its coordinates and holds it stable until the consumer accepts it.
module pix_out_reg
    import gpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [PIX_W-1:0]   i_data,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [PIX_W-1:0]   o_data,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_accept
);

    logic               r_valid;
    logic [PIX_W-1:0]   r_data;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_x     <= i_x;
            r_y     <= i_y;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_accept = r_valid & i_ready;

endmodule

// File: rtl/pixel_compositor.sv
// Layered pixel compositor: reads layers front to back for each pixel, skips
// colour-keyed layers and emits the first opaque colour (or the background).
module pixel_compositor
    import gpu_pkg::*;
#(
    parameter logic [PIX_W-1:0]   KEY_COLOR = DEF_KEY_COLOR,
    parameter logic [PIX_W-1:0]   BG_COLOR  = DEF_BG_COLOR,
    parameter logic [COORD_W-1:0] X_LAST    = DEF_X_LAST,
    parameter logic [COORD_W-1:0] Y_LAST    = DEF_Y_LAST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic [LAYER_W-1:0] layer,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               next_layer,
    output logic               next_pixel,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_ack,
    input  logic               rd_data_valid,
    input  logic [PIX_W-1:0]   rd_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_W-1:0]   pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_done
);

    comp_state_t         r_state;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_next_layer;
    logic                r_next_pixel;
    logic                r_frame_done;

    logic [LAYER_W-1:0]  w_req_layer;
    logic [COORD_W-1:0]  w_req_x;
    logic [COORD_W-1:0]  w_req_y;
    logic [LAYER_W-1:0]  w_last_layer;
    logic                w_on_last;
    logic                w_is_key;
    logic                w_load;
    logic [PIX_W-1:0]    w_load_data;
    logic                w_accept;
    logic                w_pix_last;

    // The issued address doubles as the captured position of the pixel in flight.
    assign w_req_layer  = r_rd_addr[ADDR_W-1 -: LAYER_W];
    assign w_req_y      = r_rd_addr[2*COORD_W-1 -: COORD_W];
    assign w_req_x      = r_rd_addr[COORD_W-1:0];

    assign w_last_layer = (num_layers == '0) ? '0 : num_layers - LAYER_W'(1);
    assign w_on_last    = (w_req_layer == w_last_layer) || (w_req_layer == '1);
    assign w_is_key     = (rd_data == KEY_COLOR);
    assign w_load       = (r_state == WAIT) && rd_data_valid && (!w_is_key || w_on_last);
    assign w_load_data  = w_is_key ? BG_COLOR : rd_data;
    assign w_pix_last   = (pix_x == X_LAST) && (pix_y == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
            r_next_layer <= 1'b0;
            r_next_pixel <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_next_layer <= 1'b0;
            r_next_pixel <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) r_state <= SETTLE;
                end
                SETTLE: r_state <= REQ;
                REQ: begin
                    // First REQ cycle registers the address; the request is live from the second.
                    if (!r_rd_req) begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= {layer, y, x};
                    end else if (rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_data_valid) begin
                        if (w_load) begin
                            r_state <= EMIT;
                        end else begin
                            r_next_layer <= 1'b1;
                            r_state      <= SETTLE;
                        end
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        r_next_pixel <= 1'b1;
                        if (w_pix_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pix_out_reg u_pix_out_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_data   (w_load_data),
        .i_x      (w_req_x),
        .i_y      (w_req_y),
        .i_ready  (pix_ready),
        .o_valid  (pix_valid),
        .o_data   (pix_data),
        .o_x      (pix_x),
        .o_y      (pix_y),
        .o_accept (w_accept)
    );

    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign next_layer = r_next_layer;
    assign next_pixel = r_next_pixel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: models the pixel counter and a zero-wait
// layer RAM, and checks composited output against hand-computed values.
module tb_pixel_compositor;
    import gpu_pkg::*;

    localparam logic [15:0] KEY = 16'hF81F;
    localparam logic [15:0] BG  = 16'h0842;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  num_layers = 5'd1;
    logic [4:0]  layer = '0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        next_layer, next_pixel, rd_req;
    logic [26:0] rd_addr;
    logic        rd_ack = 1'b0;
    logic        rd_data_valid = 1'b0;
    logic [15:0] rd_data = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [15:0] pix_data;
    logic [10:0] pix_x, pix_y;
    logic        frame_done;

    pixel_compositor #(
        .KEY_COLOR (KEY),
        .BG_COLOR  (BG),
        .X_LAST    (11'd3),
        .Y_LAST    (11'd1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .num_layers    (num_layers),
        .layer         (layer),
        .x             (x),
        .y             (y),
        .next_layer    (next_layer),
        .next_pixel    (next_pixel),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Environment state: RAM contents, response control and event counters.
    logic [15:0] lay_col [32];
    bit          frame_mode = 1'b0;
    bit          hold_valid = 1'b0;
    logic        pend = 1'b0;
    logic [15:0] pend_data = '0;
    logic [26:0] rd_log [$];
    int          cnt_nl = 0, cnt_np = 0, cnt_fd = 0, n_viol = 0, n_valid_sent = 0;
    logic        prev_nl = 1'b0, prev_np = 1'b0, prev_fd = 1'b0;
    int          cyc = 0, last_np_cyc = -1, np_gap = 0;

    function automatic logic [15:0] mem_read(input logic [26:0] a);
        logic [4:0] l;
        l = a[26:22];
        if (frame_mode) return 16'h4000 + 16'(a[21:11]) * 16'd16 + 16'(a[10:0]);
        return lay_col[l];
    endfunction

    // Pixel counter + zero-wait RAM + pulse monitor, acting just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                layer = '0; x = '0; y = '0;
                rd_ack = 1'b0; rd_data_valid = 1'b0;
                prev_nl = 1'b0; prev_np = 1'b0; prev_fd = 1'b0;
                last_np_cyc = -1;
            end else begin
                if (next_layer && next_pixel) n_viol++;
                if (next_layer && prev_nl) n_viol++;
                if (next_pixel && prev_np) n_viol++;
                if (frame_done && prev_fd) n_viol++;
                prev_nl = next_layer; prev_np = next_pixel; prev_fd = frame_done;
                if (next_layer) begin
                    cnt_nl++;
                    layer = layer + 5'd1;
                end
                if (next_pixel) begin
                    cnt_np++;
                    if (last_np_cyc >= 0) np_gap = cyc - last_np_cyc;
                    last_np_cyc = cyc;
                    layer = '0;
                    if (x == 11'd3) begin
                        x = '0;
                        y = (y == 11'd1) ? 11'd0 : y + 11'd1;
                    end else begin
                        x = x + 11'd1;
                    end
                end
                if (frame_done) cnt_fd++;
                if (pend && !hold_valid) begin
                    rd_data_valid = 1'b1;
                    rd_data = pend_data;
                    pend = 1'b0;
                    n_valid_sent++;
                end else begin
                    rd_data_valid = 1'b0;
                end
                if (rd_req) begin
                    rd_ack = 1'b1;
                    pend = 1'b1;
                    pend_data = mem_read(rd_addr);
                    rd_log.push_back(rd_addr);
                end else begin
                    rd_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; pix_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!pix_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid_timeout"}, 32'(pix_valid), 32'd1);
    endtask

    task automatic accept_one();
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
    endtask

    task automatic one_pixel(input string tag, input logic [4:0] nl, input logic [15:0] exp_data,
                             input int exp_reads, input int exp_nl);
        int base, nl0, np0;
        do_reset();
        num_layers = nl;
        base = rd_log.size(); nl0 = cnt_nl; np0 = cnt_np;
        start_frame();
        wait_valid(tag);
        check_eq({tag, "_data"}, 32'(pix_data), 32'(exp_data));
        check_eq({tag, "_xy"}, {10'd0, pix_x, pix_y}, 32'd0);
        check_eq({tag, "_reads"}, 32'(rd_log.size() - base), 32'(exp_reads));
        check_eq({tag, "_next_layer"}, 32'(cnt_nl - nl0), 32'(exp_nl));
        for (int i = 0; i < exp_reads; i++)
            check_eq($sformatf("%s_addr%0d", tag, i),
                     (rd_log.size() > base + i) ? 32'(rd_log[base + i]) : 32'hFFFF_FFFF,
                     32'({5'(i), 22'd0}));
        accept_one();
        check_eq({tag, "_next_pixel"}, 32'(cnt_np - np0), 32'd1);
        check_eq({tag, "_valid_drop"}, 32'(pix_valid), 32'd0);
    endtask

    initial begin
        int base, nl0, np0, fd0, sent0, n_unst, t_acc, t_fd, tick, n;
        bit done;
        logic [15:0] px_d [$];
        logic [21:0] px_xy [$];

        foreach (lay_col[i]) lay_col[i] = KEY;

        // Reset state
        do_reset();
        check_eq("rst_rd_req", 32'(rd_req), 32'd0);
        check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_pix_data", 32'(pix_data), 32'd0);
        check_eq("rst_pix_xy", {10'd0, pix_x, pix_y}, 32'd0);
        check_eq("rst_pulses", {29'd0, next_layer, next_pixel, frame_done}, 32'd0);

        // Front layer opaque
        lay_col[0] = 16'h1234;
        one_pixel("t1", 5'd3, 16'h1234, 1, 0);

        // Two keyed layers, third wins
        lay_col[0] = KEY; lay_col[1] = KEY; lay_col[2] = 16'h07E0;
        one_pixel("t2", 5'd3, 16'h07E0, 3, 2);

        // All keyed -> background; zero layers behaves as one
        lay_col[2] = KEY;
        one_pixel("t3a", 5'd2, BG, 2, 1);
        one_pixel("t3b", 5'd0, BG, 1, 0);

        // Back-pressure in EMIT
        do_reset();
        lay_col[0] = 16'hABCD; num_layers = 5'd1;
        np0 = cnt_np;
        start_frame();
        wait_valid("t4");
        n_unst = 0;
        repeat (10) begin
            @(negedge clk);
            if (pix_valid !== 1'b1 || pix_data !== 16'hABCD || pix_x !== 11'd0 || pix_y !== 11'd0)
                n_unst++;
        end
        check_eq("t4_stall_stable", 32'(n_unst), 32'd0);
        check_eq("t4_stall_no_np", 32'(cnt_np - np0), 32'd0);
        accept_one();
        @(negedge clk);
        check_eq("t4_np_once", 32'(cnt_np - np0), 32'd1);

        // Full 4x2 frame with enable dropped mid-frame
        do_reset();
        frame_mode = 1'b1; num_layers = 5'd2;
        base = rd_log.size(); fd0 = cnt_fd;
        pix_ready = 1'b1;
        start_frame();
        t_acc = -100; t_fd = -50; tick = 0; done = 1'b0;
        while (!done && tick < 300) begin
            @(negedge clk);
            tick++;
            if (frame_done) begin
                t_fd = tick;
                done = 1'b1;
            end
            if (pix_valid && pix_ready) begin
                px_d.push_back(pix_data);
                px_xy.push_back({pix_x, pix_y});
                if (pix_x == 11'd3 && pix_y == 11'd1) t_acc = tick;
            end
        end
        pix_ready = 1'b0;
        check_eq("t5_frame_timeout", 32'(done), 32'd1);
        check_eq("t5_pix_count", 32'(px_d.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < px_d.size()) begin
                check_eq($sformatf("t5_px%0d_data", i), 32'(px_d[i]),
                         32'(16'h4000 + 16'((i / 4) * 16 + (i % 4))));
                check_eq($sformatf("t5_px%0d_xy", i), 32'(px_xy[i]),
                         32'({11'(i % 4), 11'(i / 4)}));
            end
        end
        check_eq("t5_fd_delay", 32'(t_fd - t_acc), 32'd1);
        check_eq("t5_fd_count", 32'(cnt_fd - fd0), 32'd1);
        check_eq("t5_reads", 32'(rd_log.size() - base), 32'd8);
        check_eq("t5_pixel_period", 32'(np_gap), 32'd5);
        repeat (5) @(negedge clk);
        check_eq("t5_idle", 32'(dut.r_state), 32'(IDLE));
        check_eq("t5_no_more_reads", 32'(rd_log.size() - base), 32'd8);
        frame_mode = 1'b0;

        // Reset while waiting for read data; late data must be ignored
        do_reset();
        lay_col[0] = 16'h1111; num_layers = 5'd1;
        hold_valid = 1'b1;
        base = rd_log.size();
        start_frame();
        n = 0;
        while (rd_log.size() == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_read_issued", 32'(rd_log.size() - base), 32'd1);
        repeat (2) @(negedge clk);
        nl0 = cnt_nl; np0 = cnt_np; fd0 = cnt_fd; sent0 = n_valid_sent;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t6_late_data_sent", 32'(n_valid_sent - sent0), 32'd1);
        check_eq("t6_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("t6_pix_data", 32'(pix_data), 32'd0);
        check_eq("t6_pix_xy", {10'd0, pix_x, pix_y}, 32'd0);
        check_eq("t6_rd_req", 32'(rd_req), 32'd0);
        check_eq("t6_rd_addr", 32'(rd_addr), 32'd0);
        check_eq("t6_state", 32'(dut.r_state), 32'(IDLE));
        check_eq("t6_pulses", 32'((cnt_nl - nl0) + (cnt_np - np0) + (cnt_fd - fd0)), 32'd0);

        check_eq("pulse_rules", 32'(n_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
